// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Brief    : Clocked SRAM device model driven by csBar/oeBar/weBar strobes,
//            with fixed read latency and a sticky protocol-violation flag.
//            Optional per-word even parity: define SRAM_RESP_PARITY_EN.
// Revision : 1.0
// ============================================================================
module sram_responder #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csBar,
    input  logic              oeBar,
    input  logic              weBar,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataOutEn,
    output logic              protocolErr,
    output logic [15:0]       writeCount,
    output logic              parityErr
);

    localparam int         c_DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] c_LAT_M1   = 4'(READ_LAT - 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_SEL      = 3'd1;
    localparam logic [2:0] c_RD_WAIT  = 3'd2;
    localparam logic [2:0] c_RD_DRIVE = 3'd3;
    localparam logic [2:0] c_WR       = 3'd4;
    localparam logic [2:0] c_ERR      = 3'd5;

    logic [2:0]        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] dout_q,   dout_d;
    logic              douten_q, douten_d;
    logic              perr_q,   perr_d;
    logic [15:0]       wcnt_q,   wcnt_d;

    logic              w_commit;
    logic              w_rd_load;
    logic              w_par_err;
    logic [DATA_W-1:0] w_rd_word;

    logic [DATA_W-1:0] mem [c_DEPTH];

    assign w_rd_word = mem[addr_q];

    // State register: all control state clears asynchronously; the array does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= c_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            dout_q   <= '0;
            douten_q <= 1'b0;
            perr_q   <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            dout_q   <= dout_d;
            douten_q <= douten_d;
            perr_q   <= perr_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Next-state: simultaneous oe/we while selected overrides everything else.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        douten_d  = douten_q;
        perr_d    = perr_q;
        wcnt_d    = wcnt_q;
        w_commit  = 1'b0;
        w_rd_load = 1'b0;
        if (!csBar && !oeBar && !weBar) begin
            state_d  = c_ERR;
            perr_d   = 1'b1;
            douten_d = 1'b0;
        end else if (csBar) begin
            state_d  = c_IDLE;
            douten_d = 1'b0;
            w_commit = (state_q == c_WR);
        end else begin
            case (state_q)
                c_IDLE: begin
                    state_d = c_SEL;
                    addr_d  = addr;
                end
                c_SEL: begin
                    if (!oeBar && weBar) begin
                        state_d = c_RD_WAIT;
                        cnt_d   = c_LAT_M1;
                    end else if (!weBar && oeBar) begin
                        state_d = c_WR;
                        wdata_d = dataIn;
                    end
                end
                c_RD_WAIT: begin
                    if (oeBar) begin
                        state_d = c_SEL;
                    end else if (cnt_q == 4'd0) begin
                        state_d   = c_RD_DRIVE;
                        dout_d    = w_rd_word;
                        douten_d  = 1'b1;
                        w_rd_load = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                c_RD_DRIVE: begin
                    if (oeBar) begin
                        state_d  = c_SEL;
                        douten_d = 1'b0;
                    end
                end
                c_WR: begin
                    if (!weBar) begin
                        wdata_d = dataIn;
                    end else begin
                        w_commit = 1'b1;
                        state_d  = c_SEL;
                    end
                end
                c_ERR:   state_d = c_ERR;
                default: state_d = c_IDLE;
            endcase
        end
        if (w_commit) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            mem[addr_q] <= wdata_q;
        end
    end

`ifdef SRAM_RESP_PARITY_EN
    logic mem_par [c_DEPTH];
    logic par_err_q, par_err_d;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            mem_par[addr_q] <= ^wdata_q;
        end
    end

    always_comb begin
        par_err_d = par_err_q;
        if (w_rd_load) begin
            par_err_d = (mem_par[addr_q] != (^w_rd_word));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign w_par_err = par_err_q;
`else
    assign w_par_err = 1'b0;
`endif

    always_comb begin
        dataOut     = dout_q;
        dataOutEn   = douten_q;
        protocolErr = perr_q;
        writeCount  = wcnt_q;
        parityErr   = w_par_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_responder
// Brief    : Self-checking bench for sram_responder; transaction-level memory
//            model with randomized addresses, data and strobe hold times.
// Revision : 1.0
// ============================================================================
module tb_sram_responder;

    localparam int READ_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csBar = 1'b1;
    logic        oeBar = 1'b1;
    logic        weBar = 1'b1;
    logic [7:0]  addr = 8'h00;
    logic [7:0]  dataIn = 8'h00;
    logic [7:0]  dataOut;
    logic        dataOutEn;
    logic        protocolErr;
    logic [15:0] writeCount;
    logic        parityErr;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_m [256];
    int          written_q [$];
    logic [15:0] wcnt_m = 16'd0;
    logic        perr_m = 1'b0;
    logic [7:0]  cur_a;
    logic [7:0]  dout_m = 8'h00;

    sram_responder #(.ADDR_W(8), .DATA_W(8), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .reset(reset), .csBar(csBar), .oeBar(oeBar), .weBar(weBar),
        .addr(addr), .dataIn(dataIn), .dataOut(dataOut), .dataOutEn(dataOutEn),
        .protocolErr(protocolErr), .writeCount(writeCount), .parityErr(parityErr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note_write(input logic [7:0] a, input logic [7:0] d);
        mem_m[a] = d;
        written_q.push_back(int'(a));
        wcnt_m = wcnt_m + 16'd1;
    endtask

    task automatic sel(input logic [7:0] a);
        csBar = 1'b0;
        addr  = a;
        cur_a = a;
        tick();
    endtask

    task automatic desel();
        csBar = 1'b1;
        oeBar = 1'b1;
        weBar = 1'b1;
        tick();
        chk("desel_en", 32'(dataOutEn), 32'd0);
    endtask

    // Hold weBar low for n edges; only the value present on the last one counts.
    task automatic we_pulse(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            weBar  = 1'b0;
            dataIn = (i == n - 1) ? d : 8'($urandom);
            addr   = 8'($urandom);
            tick();
            chk("wr_en_low", 32'(dataOutEn), 32'd0);
        end
    endtask

    task automatic wr_in_sel(input logic [7:0] d, input int n);
        we_pulse(d, n);
        weBar  = 1'b1;
        dataIn = 8'($urandom);
        tick();
        note_write(cur_a, d);
        chk("wr_count", 32'(writeCount), 32'(wcnt_m));
    endtask

    task automatic wr_cs_term(input logic [7:0] d, input int n);
        we_pulse(d, n);
        csBar = 1'b1;
        tick();
        weBar = 1'b1;
        note_write(cur_a, d);
        chk("cs_wr_count", 32'(writeCount), 32'(wcnt_m));
    endtask

    task automatic rd_in_sel(input int hold);
        logic [7:0] e;
        e      = mem_m[cur_a];
        addr   = 8'($urandom);
        oeBar  = 1'b0;
        tick();
        chk("rd_early", 32'(dataOutEn), 32'd0);
        for (int j = 1; j <= READ_LAT; j++) begin
            tick();
            if (j < READ_LAT) begin
                chk("rd_wait_en", 32'(dataOutEn), 32'd0);
            end else begin
                chk("rd_en", 32'(dataOutEn), 32'd1);
                chk("rd_data", 32'(dataOut), 32'(e));
            end
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("rd_hold_en", 32'(dataOutEn), 32'd1);
            chk("rd_hold_data", 32'(dataOut), 32'(e));
        end
        chk("rd_parity", 32'(parityErr), 32'd0);
        dout_m = e;
        oeBar  = 1'b1;
        tick();
        chk("rd_off_en", 32'(dataOutEn), 32'd0);
        chk("rd_off_data", 32'(dataOut), 32'(dout_m));
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        csBar = 1'b1;
        oeBar = 1'b1;
        weBar = 1'b1;
        #1;
        chk("rst_dout", 32'(dataOut), 32'd0);
        chk("rst_en", 32'(dataOutEn), 32'd0);
        chk("rst_perr", 32'(protocolErr), 32'd0);
        chk("rst_wcnt", 32'(writeCount), 32'd0);
        chk("rst_par", 32'(parityErr), 32'd0);
        for (int i = 0; i < n; i++) tick();
        reset  = 1'b0;
        wcnt_m = 16'd0;
        perr_m = 1'b0;
        dout_m = 8'h00;
    endtask

    initial begin
        logic [7:0] a, d, old;
        int op;

        // 1: reset, then write 0xA5 to 0x3C with a two-cycle weBar pulse
        #1;
        apply_reset(2);
        sel(8'h3C);
        wr_in_sel(8'hA5, 2);
        desel();
        chk("t1_wcnt", 32'(writeCount), 32'd1);
        chk("t1_perr", 32'(protocolErr), 32'd0);

        // 2: read back with fixed latency
        sel(8'h3C);
        rd_in_sel(1);
        desel();

        // 3: chip-select-terminated write, then read
        sel(8'h01);
        wr_cs_term(8'h5A, 1);
        sel(8'h01);
        rd_in_sel(0);
        desel();

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(0, 3));
            a  = 8'($urandom);
            d  = 8'($urandom);
            case (op)
                0: begin sel(a); wr_in_sel(d, int'($urandom_range(1, 3))); desel(); end
                1: begin sel(a); wr_cs_term(d, int'($urandom_range(1, 3))); end
                2: begin
                    sel(a);
                    wr_in_sel(d, int'($urandom_range(1, 2)));
                    rd_in_sel(int'($urandom_range(0, 2)));
                    desel();
                end
                default: begin
                    a = 8'(written_q[$urandom_range(0, written_q.size() - 1)]);
                    sel(a);
                    rd_in_sel(int'($urandom_range(0, 2)));
                    rd_in_sel(0);
                    desel();
                end
            endcase
        end

        // 4: protocol violation from idle, sticky across deselect and reads
        csBar = 1'b0; oeBar = 1'b0; weBar = 1'b0; addr = 8'h3C;
        tick();
        perr_m = 1'b1;
        chk("t4_perr", 32'(protocolErr), 32'(perr_m));
        chk("t4_en", 32'(dataOutEn), 32'd0);
        desel();
        chk("t4_perr_desel", 32'(protocolErr), 32'(perr_m));
        sel(8'h3C);
        rd_in_sel(0);
        desel();
        chk("t4_perr_read", 32'(protocolErr), 32'(perr_m));
        // Violation during a write must not commit it
        old = mem_m[8'h01];
        sel(8'h01);
        weBar = 1'b0; dataIn = ~old;
        tick();
        oeBar = 1'b0;
        tick();
        chk("t4_wr_err_wcnt", 32'(writeCount), 32'(wcnt_m));
        desel();
        chk("t4_wr_err_wcnt2", 32'(writeCount), 32'(wcnt_m));
        apply_reset(1);
        chk("t4_perr_cleared", 32'(protocolErr), 32'd0);
        sel(8'h01);
        rd_in_sel(0);
        desel();

        // 5: reset while driving read data drops dataOutEn without a clock edge
        sel(8'h3C);
        oeBar = 1'b0;
        for (int i = 0; i <= READ_LAT; i++) tick();
        chk("t5_driving", 32'(dataOutEn), 32'd1);
        reset = 1'b1;
        #2;
        chk("t5_async_en", 32'(dataOutEn), 32'd0);
        chk("t5_async_dout", 32'(dataOut), 32'd0);
        apply_reset(1);
        chk("t5_wcnt", 32'(writeCount), 32'd0);
        sel(8'h3C);
        rd_in_sel(0);
        desel();

        // Reset mid-write discards the pending word
        old = mem_m[8'h3C];
        sel(8'h3C);
        we_pulse(~old, 2);
        apply_reset(1);
        sel(8'h3C);
        rd_in_sel(0);
        desel();
        chk("mw_wcnt", 32'(writeCount), 32'd0);

        // 6: writeCount wraps; preload near the top to keep the run short
        force dut.wcnt_q = 16'hFFFD;
        tick();
        release dut.wcnt_q;
        wcnt_m = 16'hFFFD;
        sel(8'h10);
        wr_in_sel(8'h11, 1);
        wr_in_sel(8'h22, 1);
        chk("t6_wcnt_max", 32'(writeCount), 32'h0000FFFF);
        wr_in_sel(8'h33, 1);
        chk("t6_wcnt_wrap", 32'(writeCount), 32'h00000000);
        rd_in_sel(0);
        desel();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
